// File: rtl/glm_load_scheduler_if.sv
// Handshake bundle between glm_load_scheduler, its requesters and the shared glm_load instance.
interface glm_load_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      done;
  logic                    grant_valid;
  logic [LOG2_NUM_REQ-1:0] grant_idx;
  logic                    load_op_start;
  logic                    load_op_done;
  logic                    busy;
  logic                    err_spurious;
  logic                    err_timeout;

  modport master (
    input  req, load_op_done,
    output done, grant_valid, grant_idx, load_op_start, busy, err_spurious, err_timeout
  );

  modport slave (
    output req, load_op_done,
    input  done, grant_valid, grant_idx, load_op_start, busy, err_spurious, err_timeout
  );
endinterface

// File: rtl/glm_load_scheduler.sv
// Round-robin owner arbitration for one shared glm_load instance.
// Optional WAIT watchdog enabled by defining GLM_LOAD_SCHED_WATCHDOG_EN.
module glm_load_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2
`ifdef GLM_LOAD_SCHED_WATCHDOG_EN
  , parameter int unsigned WATCHDOG_CYCLES = 1048576
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  glm_load_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [LOG2_NUM_REQ-1:0] LAST_RST = LOG2_NUM_REQ'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]      ONE_HOT0 = NUM_REQ'(1'b1);

  state_e                  state_q, state_d;
  logic [LOG2_NUM_REQ-1:0] last_grant_q, last_grant_d;
  logic [LOG2_NUM_REQ-1:0] grant_idx_q, grant_idx_d;
  logic [LOG2_NUM_REQ-1:0] winner_s;
  logic                    found_s;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    err_spurious_q, err_spurious_d;
  logic                    err_timeout_q, err_timeout_d;

  // Round-robin pick: scan upward from the slot after the last finished owner, wrapping.
  always_comb begin : arb
    int k;
    found_s  = 1'b0;
    winner_s = {LOG2_NUM_REQ{1'b0}};
    k        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = int'(last_grant_q) + i;
      k = (k >= NUM_REQ) ? (k - NUM_REQ) : k;
      if (!found_s && bus.req[k]) begin
        winner_s = LOG2_NUM_REQ'(k);
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Next-state and registered-output computation for the grant FSM.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_idx_d    = grant_idx_q;
    grant_valid_d  = grant_valid_q;
    start_d        = 1'b0;
    done_d         = {NUM_REQ{1'b0}};
    err_spurious_d = err_spurious_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d       = S_SETUP;
          grant_idx_d   = winner_s;
          grant_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done coincident with our own start pulse cannot be genuine.
        if (bus.load_op_done && !start_q) begin
          done_d       = ONE_HOT0 << grant_idx_q;
          last_grant_d = grant_idx_q;
          state_d      = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RELEASE: begin
        grant_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
    if (bus.load_op_done && ((state_q != S_WAIT) || start_q)) begin
      err_spurious_d = 1'b1;
    end else begin
      err_spurious_d = err_spurious_q;
    end
    busy_d = (state_d != S_IDLE);
  end

`ifdef GLM_LOAD_SCHED_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 32'd1);

  logic [31:0] wd_cnt_q, wd_cnt_d;

  // Counts WAIT cycles; held at zero elsewhere so it starts from 0 on WAIT entry.
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
      if (wd_cnt_q == WD_LAST) begin
        err_timeout_d = 1'b1;
      end else begin
        err_timeout_d = err_timeout_q;
      end
    end else begin
      wd_cnt_d = 32'd0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= 32'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign err_timeout_d = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= LAST_RST;
      grant_idx_q    <= {LOG2_NUM_REQ{1'b0}};
      grant_valid_q  <= 1'b0;
      start_q        <= 1'b0;
      done_q         <= {NUM_REQ{1'b0}};
      busy_q         <= 1'b0;
      err_spurious_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_idx_q    <= grant_idx_d;
      grant_valid_q  <= grant_valid_d;
      start_q        <= start_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      err_spurious_q <= err_spurious_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bus.done          = done_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_idx     = grant_idx_q;
  assign bus.load_op_start = start_q;
  assign bus.busy          = busy_q;
  assign bus.err_spurious  = err_spurious_q;
  assign bus.err_timeout   = err_timeout_q;

endmodule
